// File: rtl/timing_gen.sv
// timing_gen: bit- and word-time generator for the G-15 core.
//
// A bit counter (1..BITS) and a word counter (0..WORDS-1) advance once per
// enabled CLOCK cycle. All outputs are decodes of registered state only.
//
// Optional feature macro: G15_TIMING_CHECK_EN
//   defined     -> sticky SYNC_ERR flags an ORIGIN mark that arrives anywhere
//                  other than the last bit time of a revolution.
//   not defined -> no error register; SYNC_ERR is tied low.
// ORIGIN re-alignment of the counters is present in both builds.

module timing_gen #(
    parameter int WORDS = 108,
    parameter int BITS  = 29
) (
    input  logic       CLOCK,
    input  logic       rst,
    input  logic       BIT_EN,
    input  logic       ORIGIN,
    output logic [4:0] BIT,
    output logic [6:0] WORD,
    output logic       T1,
    output logic       T2,
    output logic       T13,
    output logic       T21,
    output logic       T28,
    output logic       T29,
    output logic       WODD,
    output logic       TE,
    output logic       REV_END,
    output logic       SYNC_ERR
);

    localparam logic [4:0] BIT_FIRST = 5'd1;
    localparam logic [4:0] BIT_LAST  = 5'(BITS);
    localparam logic [6:0] WORD_LAST = 7'(WORDS - 1);

    logic [4:0] bit_q;
    logic [6:0] word_q;
    logic       bit_last;
    logic       rev_end;

    assign bit_last = (bit_q == BIT_LAST);
    assign rev_end  = bit_last && (word_q == WORD_LAST);

    // Bit/word counters: origin re-aligns, otherwise bit wraps 29->1 and carries into word.
    always_ff @(posedge CLOCK or negedge rst) begin
        if (!rst) begin
            bit_q  <= BIT_FIRST;
            word_q <= '0;
        end else if (BIT_EN) begin
            if (ORIGIN) begin
                bit_q  <= BIT_FIRST;
                word_q <= '0;
            end else if (bit_last) begin
                bit_q  <= BIT_FIRST;
                word_q <= (word_q == WORD_LAST) ? 7'd0 : word_q + 7'd1;
            end else begin
                bit_q  <= bit_q + 5'd1;
            end
        end
    end

`ifdef G15_TIMING_CHECK_EN
    logic err_q;

    // Sticky misalignment flag: an origin mark is only expected at the revolution's last bit.
    always_ff @(posedge CLOCK or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if (BIT_EN && ORIGIN && !rev_end) begin
            err_q <= 1'b1;
        end
    end

    assign SYNC_ERR = err_q;
`else
    assign SYNC_ERR = 1'b0;
`endif

    assign BIT     = bit_q;
    assign WORD    = word_q;
    assign T1      = (bit_q == 5'd1);
    assign T2      = (bit_q == 5'd2);
    assign T13     = (bit_q == 5'd13);
    assign T21     = (bit_q == 5'd21);
    assign T28     = (bit_q == 5'd28);
    assign T29     = (bit_q == 5'd29);
    assign WODD    = word_q[0];
    assign TE      = T29 && word_q[0];
    assign REV_END = rev_end;

endmodule

// File: tb/tb_timing_gen.sv
// tb_timing_gen: self-checking bench for timing_gen. The reference model tracks
// a single linear position within the revolution (0..3131) and derives the
// expected bit/word/decodes from it arithmetically.

module tb_timing_gen;

    localparam int NBITS  = 29;
    localparam int NWORDS = 108;
    localparam int NREV   = NBITS * NWORDS;

    logic       CLOCK;
    logic       rst;
    logic       BIT_EN;
    logic       ORIGIN;
    logic [4:0] BIT;
    logic [6:0] WORD;
    logic       T1, T2, T13, T21, T28, T29;
    logic       WODD, TE, REV_END, SYNC_ERR;

    int errors = 0;
    int checks = 0;

    // reference model state
    int m_pos = 0;
    bit m_err = 0;

    timing_gen dut (
        .CLOCK    (CLOCK),
        .rst      (rst),
        .BIT_EN   (BIT_EN),
        .ORIGIN   (ORIGIN),
        .BIT      (BIT),
        .WORD     (WORD),
        .T1       (T1),
        .T2       (T2),
        .T13      (T13),
        .T21      (T21),
        .T28      (T28),
        .T29      (T29),
        .WODD     (WODD),
        .TE       (TE),
        .REV_END  (REV_END),
        .SYNC_ERR (SYNC_ERR)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (pos %0d)", tag, got, exp, m_pos);
        end
    endtask

    task automatic check_all();
        int eb;
        int ew;
        bit ee;
        eb = (m_pos % NBITS) + 1;
        ew = m_pos / NBITS;
`ifdef G15_TIMING_CHECK_EN
        ee = m_err;
`else
        ee = 1'b0;
`endif
        chk("BIT",      32'(BIT),      32'(eb));
        chk("WORD",     32'(WORD),     32'(ew));
        chk("T1",       32'(T1),       32'(eb == 1));
        chk("T2",       32'(T2),       32'(eb == 2));
        chk("T13",      32'(T13),      32'(eb == 13));
        chk("T21",      32'(T21),      32'(eb == 21));
        chk("T28",      32'(T28),      32'(eb == 28));
        chk("T29",      32'(T29),      32'(eb == 29));
        chk("WODD",     32'(WODD),     32'(ew % 2));
        chk("TE",       32'(TE),       32'((eb == 29) && (ew % 2 == 1)));
        chk("REV_END",  32'(REV_END),  32'(m_pos == NREV - 1));
        chk("SYNC_ERR", 32'(SYNC_ERR), 32'(ee));
    endtask

    // Called just after a falling edge: drive inputs, clock once, check at next falling edge.
    task automatic step(input bit en, input bit org);
        BIT_EN = en;
        ORIGIN = org;
        if (en) begin
            if (org) begin
                if (m_pos != NREV - 1) m_err = 1'b1;
                m_pos = 0;
            end else begin
                m_pos = (m_pos + 1) % NREV;
            end
        end
        @(posedge CLOCK);
        @(negedge CLOCK);
        check_all();
    endtask

    task automatic run_to(input int target);
        int n;
        n = 0;
        while (m_pos != target && n < 2 * NREV) begin
            step(1'b1, 1'b0);
            n++;
        end
    endtask

    task automatic do_reset();
        rst    = 1'b0;
        BIT_EN = 1'b1;
        ORIGIN = 1'b0;
        m_pos  = 0;
        m_err  = 1'b0;
        repeat (5) @(posedge CLOCK);
        @(negedge CLOCK);
        check_all();
        rst = 1'b1;
    endtask

    initial begin
        rst    = 1'b0;
        BIT_EN = 1'b0;
        ORIGIN = 1'b0;

        // reset and first word
        do_reset();
        chk("rst_bit", 32'(BIT), 32'd1);
        step(1'b1, 1'b0);
        chk("rel_bit2", 32'(BIT), 32'd2);
        chk("rel_t2", 32'(T2), 32'd1);
        repeat (27) step(1'b1, 1'b0);
        chk("bit29", 32'(BIT), 32'd29);
        step(1'b1, 1'b0);
        chk("word1_bit", 32'(BIT), 32'd1);
        chk("word1_word", 32'(WORD), 32'd1);

        // pair strobe: TE at word 1 bit 29
        run_to(57);
        chk("te_pair", 32'(TE), 32'd1);

        // natural revolution wrap
        run_to(NREV - 1);
        chk("rev_end", 32'(REV_END), 32'd1);
        chk("rev_te", 32'(TE), 32'd1);
        step(1'b1, 1'b0);
        chk("wrap_word", 32'(WORD), 32'd0);

        // aligned origin in the REV_END cycle
        run_to(NREV - 1);
        step(1'b1, 1'b1);
        chk("aligned_bit", 32'(BIT), 32'd1);
        chk("aligned_err", 32'(SYNC_ERR), 32'd0);

        // enable gating from word 3 bit 5
        run_to(3 * NBITS + 4);
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        chk("gate_hold", 32'(BIT), 32'd6);
        step(1'b1, 1'b0);
        chk("gate_bit", 32'(BIT), 32'd7);

        // misaligned origin at word 40 bit 12
        run_to(40 * NBITS + 11);
        step(1'b1, 1'b1);
        chk("mis_word", 32'(WORD), 32'd0);
        run_to(NREV - 1);
        step(1'b1, 1'b1);

        // held origin after a fresh reset: second cycle flags
        do_reset();
        run_to(NREV - 1);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);

        // async reset mid-word at word 17 bit 20
        run_to(17 * NBITS + 19);
        #2 rst = 1'b0;
        m_pos = 0;
        m_err = 1'b0;
        #1;
        check_all();
        @(negedge CLOCK);
        rst = 1'b1;
        step(1'b1, 1'b0);
        chk("post_arst_bit", 32'(BIT), 32'd2);

        // randomized enable/origin traffic
        for (int i = 0; i < 8000; i++) begin
            step(($urandom % 4) != 0, ($urandom % 300) == 0);
            if (($urandom % 2000) == 0) begin
                step(1'b1, 1'b1);
                step(1'b1, 1'b1);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/timing_gen.md
# timing_gen

Bit- and word-time generator for the G-15 core. Advances a 29-bit-per-word, 108-word-per-revolution timing counter once per enabled CLOCK cycle. Drives the bit-time decodes (T1, T2, T13, T21, T28, T29), the odd-word and end-of-pair strobe TE, and the word number consumed by the product gates, the early bus and the drum tracks. An optional origin mark re-aligns the counters to the physical drum origin.

## Interface
- WORDS, default 108: words per drum revolution; word counter range is 0..WORDS-1.
- BITS, default 29: bit times per word; bit counter range is 1..BITS.
- CLOCK  in  1  system clock; one bit time per cycle with BIT_EN high.
- rst  in  1  asynchronous, active-low reset; the block is in reset while rst=0.
- BIT_EN  in  1  advance enable; counters hold while low.
- ORIGIN  in  1  drum origin mark; sampled only when BIT_EN=1.
- BIT  out  5  current bit number, 1..29.
- WORD  out  7  current word number, 0..107.
- T1, T2, T13, T21, T28, T29  out  1 each  one-hot decodes of BIT.
- WODD  out  1  WORD[0]; high during odd words.
- TE  out  1  T29 & WODD; end of a double-precision word pair.
- REV_END  out  1  T29 & (WORD==107); last bit time of a revolution.
- SYNC_ERR  out  1  sticky origin-misalignment flag (see Configuration).

## Operation
- State: bit_q (5 b), word_q (7 b), err_q (1 b). Every output is a pure decode of these registers; there is no combinational path from any input to any output.
- Reset (rst=0, asynchronous): bit_q=1, word_q=0, err_q=0.
  - Resulting outputs: BIT=1, WORD=0, T1=1, all other T*=0, WODD=0, TE=0, REV_END=0, SYNC_ERR=0.
- Each rising CLOCK edge with BIT_EN=1, in this priority order:
  - ORIGIN=1: bit_q<=1, word_q<=0. With the macro, err_q<=1 unless REV_END=1 in the same cycle.
  - Otherwise, bit_q==29: bit_q<=1, and word_q<=(word_q==107) ? 0 : word_q+1.
  - Otherwise: bit_q<=bit_q+1, word_q unchanged.
- BIT_EN=0: all state holds. ORIGIN is ignored.
- ORIGIN in the same cycle as the natural wrap (bit 29, word 107) gives the same next state as the wrap and does not set err_q.
- ORIGIN held high over several enabled cycles pins the counters at bit 1, word 0. In that case err_q sets on the second such cycle.
- Arithmetic: unsigned. Word increment is modulo WORDS and bit increment is modulo BITS, with bit restarting at 1, never 0. Out-of-range values are unreachable from reset.

## Timing
- Latency: one CLOCK edge from BIT_EN/ORIGIN sample to the new BIT/WORD and decodes.
- A revolution is 29*108 = 3132 enabled cycles.
- TE pulses once per 58 enabled cycles, for one cycle. REV_END pulses once per 3132 enabled cycles.
- T29 and TE are valid in the same cycle that downstream drum tracks clock bit 29. Consumers register on the same edge that advances this block.
- Reset deassertion: the first enabled edge after rst rises moves the state to BIT=2, WORD=0. Downstream logic synchronizes rst release itself.
- Reset asserted mid-word: outputs go to reset values immediately, without waiting for a clock.

## Configuration
- G15_TIMING_CHECK_EN defined: err_q implements the misalignment check above. SYNC_ERR=err_q, sticky until rst.
- Not defined: err_q and its logic are omitted, and SYNC_ERR is tied 0. ORIGIN re-alignment itself is always present.

## Test plan
- Reset: hold rst=0 for 5 cycles with BIT_EN=1.
  - Required: BIT=1, WORD=0, T1=1, TE=0, REV_END=0, SYNC_ERR=0.
  - Release rst. After 1 cycle BIT=2 and T2=1. After 28 cycles BIT=29 and T29=1. Next cycle BIT=1, WORD=1.
- Pair strobe: run 58 cycles from reset.
  - Required: TE=1 only at WORD=1, BIT=29 (cycle 57).
  - WODD toggles at each word boundary.
- Revolution wrap: run to WORD=107, BIT=29.
  - Required: REV_END=1 and TE=1 in that cycle. Next cycle WORD=0, BIT=1.
  - Pulse ORIGIN exactly in the REV_END cycle. Required: same result, SYNC_ERR stays 0.
- Enable gating: toggle BIT_EN 1,0,0,1 from BIT=5, WORD=3.
  - Required: BIT sequence 6,6,6,7. ORIGIN=1 during the BIT_EN=0 cycles has no effect.
- Misaligned origin: at WORD=40, BIT=12, assert ORIGIN with BIT_EN=1.
  - Required: next BIT=1, WORD=0.
  - With the macro, SYNC_ERR=1 and it persists through a later aligned origin. Without the macro, SYNC_ERR=0.
- Async reset mid-word: drop rst at WORD=17, BIT=20, between clock edges.
  - Required: outputs reach reset values before the next CLOCK edge, and SYNC_ERR clears.
